button_alu_ctrl: RTL and testbench
==================================

// Module: button_alu_ctrl
// PURPOSE
//  Board-side front end for the switch/button ALU: synchronises and debounces the five push buttons,
//  turns each press into a single event, latches SW and computes the selected op sequentially
//  (8-cycle shift-add signed multiply). Drives LED with a registered result plus BUSY/VALID status.
//  Sits between the board pins and the LEDs; replaces the purely combinational ALU on hardware.
// PARAMETERS
//  BITS             16    switch/LED width; ops defined for 16 (operands SW[15:8], SW[7:0])
//  DEBOUNCE_CYCLES  1000  consecutive stable cycles before a debounced level changes (>=2)
// PORTS
//  CLK100MHZ   in   1     system clock
//  CPU_RESETN  in   1     asynchronous, active-low reset
//  SW          in   BITS  operand switches (async to clock, sampled only at capture)
//  BTNU        in   1     leading-ones position request (raw, bouncy)
//  BTND        in   1     number-of-ones request
//  BTNL        in   1     signed add request
//  BTNR        in   1     signed subtract request
//  BTNC        in   1     signed multiply request
//  LED         out  BITS  registered result of last completed op
//  BUSY        out  1     high while an op is in flight (state != IDLE)
//  VALID       out  1     one-cycle pulse on the cycle LED takes a new result
// BEHAVIOUR
//  Reset: LED=0, BUSY=0, VALID=0, FSM=IDLE, debounced levels=0, debounce counters=0, operands=0.
//   Reset asserted mid-op aborts it; LED stays 0 until the next completed op.
//  Buttons: 2-flop synchroniser each; debounced level flips only after the synced input differs from it
//   for DEBOUNCE_CYCLES consecutive cycles (counter clears on any match). Press event = registered
//   0->1 edge of the debounced level; holding a button gives exactly one event; release gives none.
//  Same-cycle events: priority BTNU > BTND > BTNL > BTNR > BTNC; lower ones dropped.
//  Events arriving while BUSY=1 are dropped (not queued).
//  FSM IDLE: on event (cycle E) latch SW into sw_q and op code; -> MUL if BTNC, else CALC.
//  CALC (1 cycle): LED <= f(sw_q), VALID=1 at E+2, -> IDLE. BUSY high at E+1 only.
//  MUL (8 cycles): |a|,|b| of signed sw_q[15:8], sw_q[7:0]; unsigned shift-add, one multiplier bit
//   per cycle; on 8th cycle LED <= product, negated if operand signs differ; VALID at E+9, -> IDLE.
//   BUSY high E+1..E+8. -128*-128 = +16384 must be exact.
//  Ops (LED 16 bits, two's complement where signed):
//   U: index of highest set bit of SW +1 (0 if SW==0) in LED[4:0], LED[15:5]=0
//   D: popcount(SW) in LED[4:0], upper bits 0
//   L: sext(SW[15:8]) + sext(SW[7:0]); R: sext(SW[15:8]) - sext(SW[7:0]); C: product, 16 bits
//  SW changes after capture do not affect the in-flight result. LED holds between ops.
// TESTING (bench uses DEBOUNCE_CYCLES=4; "press" = hold clean >=8 cycles)
//  1 SW=16'h0500, press BTNU -> LED=16'h000B, VALID once at E+2; SW=16'hF0F1, BTND -> LED=16'h0009.
//  2 SW=16'h7F01, BTNL -> LED=16'h0080; SW=16'h807F, BTNR -> LED=16'hFF01 (-255).
//  3 SW=16'h8080, BTNC -> LED=16'h4000 at E+9, BUSY 8 cycles; SW=16'hFD07 -> LED=16'hFFEB (-21);
//    change SW mid-MUL -> result unchanged.
//  4 BTNL glitch toggling every 2 cycles for 20 cycles -> no VALID; then hold 50 cycles -> exactly 1 VALID.
//  5 BTNU and BTNC rise same cycle -> leading-ones result only; press BTNL during BUSY -> ignored.
//  6 CPU_RESETN low at E+4 of a MUL -> LED=0, BUSY=0, VALID=0 asynchronously; next press computes normally.

Source files
------------

// File: rtl/button_alu_ctrl.sv
// ============================================================================
// Module   : button_alu_ctrl
// Purpose  : Debounced push-button front end driving a sequential switch ALU.
//            The multiply is an 8-cycle signed shift-add; the other ops take 1 cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module button_alu_ctrl #(
    parameter int BITS            = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic            CLK100MHZ,
    input  logic            CPU_RESETN,
    input  logic [BITS-1:0] SW,
    input  logic            BTNU,
    input  logic            BTND,
    input  logic            BTNL,
    input  logic            BTNR,
    input  logic            BTNC,
    output logic [BITS-1:0] LED,
    output logic            BUSY,
    output logic            VALID
);

    localparam int c_NBTN  = 5;
    localparam int c_HALF  = BITS / 2;
    localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int c_RES_W = $clog2(BITS + 1);
    localparam int c_MUL_W = $clog2(c_HALF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_U = 3'd0,
        OP_D = 3'd1,
        OP_L = 3'd2,
        OP_R = 3'd3,
        OP_C = 3'd4
    } op_t;

    // Bit order: 4=U, 3=D, 2=L, 1=R, 0=C (matches event priority)
    logic [c_NBTN-1:0]              w_btn_raw;
    logic [c_NBTN-1:0]              r_sync1;
    logic [c_NBTN-1:0]              r_sync2;
    logic [c_NBTN-1:0]              r_db;
    logic [c_NBTN-1:0]              r_db_d;
    logic [c_NBTN-1:0]              r_evt;
    logic [c_NBTN-1:0][c_CNT_W-1:0] r_db_cnt;

    state_t               r_state;
    state_t               w_state_nxt;
    op_t                  r_op;
    op_t                  w_op;
    logic                 w_start;
    logic [BITS-1:0]      r_sw_q;
    logic [BITS-1:0]      r_acc;
    logic [BITS-1:0]      r_mcand;
    logic [c_HALF-1:0]    r_mplier;
    logic                 r_neg;
    logic [c_MUL_W-1:0]   r_mul_cnt;
    logic [BITS-1:0]      r_led;
    logic                 r_valid;

    logic [c_HALF-1:0]    w_abs_a;
    logic [c_HALF-1:0]    w_abs_b;
    logic [BITS-1:0]      w_prod;
    logic [BITS-1:0]      w_prod_signed;
    logic [BITS-1:0]      w_calc;
    logic [c_RES_W-1:0]   w_lead;
    logic [c_RES_W-1:0]   w_pop;
    logic [BITS-1:0]      w_sa;
    logic [BITS-1:0]      w_sb;

    assign w_btn_raw = {BTNU, BTND, BTNL, BTNR, BTNC};

    // Synchronise, debounce, and turn each debounced rising edge into a 1-cycle event
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_db     <= '0;
            r_db_d   <= '0;
            r_evt    <= '0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            r_evt   <= r_db & ~r_db_d;
            for (int i = 0; i < c_NBTN; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == c_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_start = 1'b1;
        w_op    = OP_U;
        if (r_evt[4])      w_op = OP_U;
        else if (r_evt[3]) w_op = OP_D;
        else if (r_evt[2]) w_op = OP_L;
        else if (r_evt[1]) w_op = OP_R;
        else if (r_evt[0]) w_op = OP_C;
        else               w_start = 1'b0;
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) r_state <= S_IDLE;
        else             r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = (w_op == OP_C) ? S_MUL : S_CALC;
            end
            S_CALC: w_state_nxt = S_IDLE;
            S_MUL: begin
                if (r_mul_cnt == c_MUL_W'(c_HALF - 1)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Magnitudes taken straight from SW so the multiplier is ready on the first MUL cycle
    assign w_abs_a = SW[BITS-1]   ? (~SW[BITS-1:c_HALF] + 1'b1) : SW[BITS-1:c_HALF];
    assign w_abs_b = SW[c_HALF-1] ? (~SW[c_HALF-1:0] + 1'b1)    : SW[c_HALF-1:0];

    assign w_prod        = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod_signed = r_neg ? (~w_prod + 1'b1) : w_prod;

    assign w_sa = {{c_HALF{r_sw_q[BITS-1]}},   r_sw_q[BITS-1:c_HALF]};
    assign w_sb = {{c_HALF{r_sw_q[c_HALF-1]}}, r_sw_q[c_HALF-1:0]};

    always_comb begin
        w_lead = '0;
        w_pop  = '0;
        for (int i = 0; i < BITS; i++) begin
            if (r_sw_q[i]) w_lead = c_RES_W'(i + 1);
            w_pop = w_pop + c_RES_W'(r_sw_q[i]);
        end
        case (r_op)
            OP_U:    w_calc = BITS'(w_lead);
            OP_D:    w_calc = BITS'(w_pop);
            OP_L:    w_calc = w_sa + w_sb;
            OP_R:    w_calc = w_sa - w_sb;
            default: w_calc = '0;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_sw_q    <= '0;
            r_op      <= OP_U;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_neg     <= 1'b0;
            r_mul_cnt <= '0;
            r_led     <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_sw_q    <= SW;
                        r_op      <= w_op;
                        r_acc     <= '0;
                        r_mcand   <= BITS'(w_abs_a);
                        r_mplier  <= w_abs_b;
                        r_neg     <= SW[BITS-1] ^ SW[c_HALF-1];
                        r_mul_cnt <= '0;
                    end
                end
                S_CALC: begin
                    r_led   <= w_calc;
                    r_valid <= 1'b1;
                end
                S_MUL: begin
                    r_acc     <= w_prod;
                    r_mcand   <= r_mcand << 1;
                    r_mplier  <= r_mplier >> 1;
                    r_mul_cnt <= r_mul_cnt + 1'b1;
                    if (r_mul_cnt == c_MUL_W'(c_HALF - 1)) begin
                        r_led   <= w_prod_signed;
                        r_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign LED   = r_led;
    assign VALID = r_valid;
    assign BUSY  = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_button_alu_ctrl.sv
// Directed bench for button_alu_ctrl: table of single-button ops plus hand-written
// glitch, same-cycle priority, busy-drop and mid-op reset sequences.
`default_nettype none

module tb_button_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sw_r = '0;
    logic        btnu = 1'b0, btnd = 1'b0, btnl = 1'b0, btnr = 1'b0, btnc = 1'b0;
    logic [15:0] led;
    logic        busy, valid;

    int n_vec = 0;
    int n_err = 0;
    int valid_cnt = 0;

    button_alu_ctrl #(.BITS(16), .DEBOUNCE_CYCLES(4)) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .SW        (sw_r),
        .BTNU      (btnu),
        .BTND      (btnd),
        .BTNL      (btnl),
        .BTNR      (btnr),
        .BTNC      (btnc),
        .LED       (led),
        .BUSY      (busy),
        .VALID     (valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (valid) valid_cnt++;
    end

    typedef struct {
        logic [15:0] sw;
        logic [4:0]  btn;
        logic [15:0] exp;
        bit          mul;
        bit          chg;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_btns(input logic [4:0] b);
        {btnu, btnd, btnl, btnr, btnc} = b;
    endtask

    task automatic wait_busy(input string name);
        int t = 0;
        while (!busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check(name, busy, 1);
    endtask

    task automatic run_op(input logic [15:0] sw, input logic [4:0] btn,
                          input logic [15:0] exp, input bit mul, input bit chg);
        int v0;
        int blen;
        @(negedge clk);
        v0   = valid_cnt;
        sw_r = sw;
        set_btns(btn);
        wait_busy("busy_start");
        blen = 0;
        while (busy && blen < 20) begin
            blen++;
            if (chg && blen == 3) sw_r = ~sw_r;
            @(negedge clk);
        end
        check("busy_len", blen, mul ? 8 : 1);
        check("valid_at_done", valid, 1);
        check("led_result", led, exp);
        @(negedge clk);
        check("valid_single_cycle", valid, 0);
        repeat (10) @(negedge clk);
        set_btns('0);
        repeat (12) @(negedge clk);
        check("valid_count_per_press", valid_cnt - v0, 1);
        check("led_hold", led, exp);
    endtask

    initial begin
        int v0;
        tbl[0]  = '{16'h0500, 5'b10000, 16'h000B, 1'b0, 1'b0};
        tbl[1]  = '{16'hF0F1, 5'b01000, 16'h0009, 1'b0, 1'b0};
        tbl[2]  = '{16'h7F01, 5'b00100, 16'h0080, 1'b0, 1'b0};
        tbl[3]  = '{16'h807F, 5'b00010, 16'hFF01, 1'b0, 1'b0};
        tbl[4]  = '{16'h8080, 5'b00001, 16'h4000, 1'b1, 1'b0};
        tbl[5]  = '{16'hFD07, 5'b00001, 16'hFFEB, 1'b1, 1'b1};
        tbl[6]  = '{16'h0000, 5'b10000, 16'h0000, 1'b0, 1'b0};
        tbl[7]  = '{16'hFFFF, 5'b01000, 16'h0010, 1'b0, 1'b0};
        tbl[8]  = '{16'h0080, 5'b00001, 16'h0000, 1'b1, 1'b0};
        tbl[9]  = '{16'h7F7F, 5'b00001, 16'h3F01, 1'b1, 1'b0};
        tbl[10] = '{16'h8001, 5'b00001, 16'hFF80, 1'b1, 1'b0};
        tbl[11] = '{16'h8080, 5'b00100, 16'hFF00, 1'b0, 1'b0};
        tbl[12] = '{16'h8000, 5'b10000, 16'h0010, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_led", led, 0);
        check("reset_busy", busy, 0);
        check("reset_valid", valid, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 13; i++)
            run_op(tbl[i].sw, tbl[i].btn, tbl[i].exp, tbl[i].mul, tbl[i].chg);

        // Bouncy BTNL never stays stable long enough to register
        @(negedge clk);
        v0   = valid_cnt;
        sw_r = 16'h0102;
        for (int i = 0; i < 10; i++) begin
            btnl = ~btnl;
            repeat (2) @(negedge clk);
        end
        btnl = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_no_valid", valid_cnt - v0, 0);
        check("glitch_no_busy", busy, 0);
        run_op(16'h0102, 5'b00100, 16'h0003, 1'b0, 1'b0);

        // U and C rise together: only the leading-ones op runs
        run_op(16'h0500, 5'b10001, 16'h000B, 1'b0, 1'b0);

        // BTNL event lands one cycle into a multiply and is dropped
        @(negedge clk);
        v0   = valid_cnt;
        sw_r = 16'h0203;
        btnc = 1'b1;
        @(negedge clk);
        btnl = 1'b1;
        wait_busy("busydrop_start");
        begin
            int t = 0;
            while (busy && t < 20) begin
                @(negedge clk);
                t++;
            end
        end
        check("busydrop_valid", valid, 1);
        check("busydrop_led", led, 16'h0006);
        repeat (20) @(negedge clk);
        check("busydrop_valid_count", valid_cnt - v0, 1);
        check("busydrop_led_hold", led, 16'h0006);
        check("busydrop_idle", busy, 0);
        set_btns('0);
        repeat (12) @(negedge clk);

        // Reset during a multiply clears outputs immediately
        sw_r = 16'h0505;
        btnc = 1'b1;
        wait_busy("rst_mul_start");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_led", led, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_valid", valid, 0);
        set_btns('0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_led_stays_zero", led, 0);
        check("rst_idle", busy, 0);
        run_op(16'hFD07, 5'b00001, 16'hFFEB, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
